// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The lane helper places one byte into its little-endian position of a word.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_START = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_STEP  = 4;
    localparam int unsigned LANE_W     = 2;

    function automatic logic [31:0] lane_insert(
        input logic [31:0]       word,
        input logic [LANE_W-1:0] lane,
        input logic [7:0]        data
    );
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: each load fills the next byte lane.
// Unfilled lanes stay zero, so a short final word is zero-padded.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  data_i,
    output logic        word_empty_o,
    output logic        word_full_o,
    output logic [31:0] word_next_o
);

    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;
    logic [31:0]       word_q;
    logic [31:0]       word_d;

    // Next lane and buffer contents; clear takes priority over a load.
    always_comb begin
        word_next_o = lane_insert(word_q, lane_q, data_i);
        lane_d      = lane_q;
        word_d      = word_q;
        if (clear_i) begin
            lane_d = {LANE_W{1'b0}};
            word_d = 32'h0000_0000;
        end else if (load_i) begin
            lane_d = lane_q + LANE_W'(1);
            word_d = word_next_o;
        end else begin
            lane_d = lane_q;
            word_d = word_q;
        end
    end

    // Lane counter and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= {LANE_W{1'b0}};
            word_q <= 32'h0000_0000;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    // word_full_o means the byte presented now completes the word.
    assign word_full_o  = (lane_q == LANE_W'(WORD_BYTES - 1));
    assign word_empty_o = (lane_q == {LANE_W{1'b0}});

endmodule

// File: rtl/imem_loader_checker.sv
// Protocol properties of the loader's output side, observed from its ports only.
module imem_loader_checker #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32,
    parameter int unsigned WCW   = 9
) (
    input logic           clk,
    input logic           rst_n,
    input logic           we_i,
    input logic [AW-1:0]  addr_i,
    input logic           start_i,
    input logic           busy_i,
    input logic           ready_i,
    input logic           error_i,
    input logic [WCW-1:0] words_i
);

    a_we_single: assert property (@(posedge clk) disable iff (!rst_n) we_i |=> !we_i)
        else $error("imem_loader: write enable held longer than one cycle");

    a_we_state: assert property (@(posedge clk) disable iff (!rst_n) we_i |-> (busy_i && !ready_i))
        else $error("imem_loader: write outside the write phase");

    a_start_single: assert property (@(posedge clk) disable iff (!rst_n) start_i |=> !start_i)
        else $error("imem_loader: start held longer than one cycle");

    a_start_state: assert property (@(posedge clk) disable iff (!rst_n) start_i |-> (!busy_i && !ready_i && !we_i))
        else $error("imem_loader: start while loading");

    a_err_state: assert property (@(posedge clk) disable iff (!rst_n) error_i |-> (!busy_i && !ready_i))
        else $error("imem_loader: error flag while accepting");

    a_addr_align: assert property (@(posedge clk) disable iff (!rst_n) addr_i[1:0] == 2'b00)
        else $error("imem_loader: unaligned address");

    a_words_bound: assert property (@(posedge clk) disable iff (!rst_n) words_i <= WCW'(DEPTH))
        else $error("imem_loader: word count beyond depth");

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into 32-bit words, writes them to consecutive
// instruction-memory addresses, then pulses start to release the processor.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   reload,
    output logic                   we_IM,
    output logic [AW-1:0]          addr_IM,
    output logic [31:0]            wdata_IM,
    output logic                   start,
    output logic                   busy,
    output logic                   error,
    output logic [$clog2(DEPTH):0] words
);

    localparam int unsigned WCW = $clog2(DEPTH) + 1;

    loader_state_t  state_q;
    logic           we_q;
    logic           start_q;
    logic           error_q;
    logic           last_q;
    logic [AW-1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [WCW-1:0] words_q;

    logic        in_ready_s;
    logic        busy_s;
    logic        hs_s;
    logic        overflow_s;
    logic        pk_load_s;
    logic        pk_clear_s;
    logic        complete_s;
    logic        rearm_s;
    logic        word_empty_s;
    logic        word_full_s;
    logic [31:0] word_next_s;

    // State decode and handshake qualification; overflow is a word-opening byte at full depth.
    always_comb begin
        in_ready_s = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        busy_s     = (state_q == ST_LOAD) || (state_q == ST_WRITE);
        hs_s       = in_valid && in_ready_s;
        overflow_s = hs_s && (state_q == ST_LOAD) && word_empty_s && (words_q == WCW'(DEPTH));
        pk_load_s  = hs_s && !overflow_s;
        complete_s = pk_load_s && (in_last || word_full_s);
        rearm_s    = reload && ((state_q == ST_DONE) || (state_q == ST_ERR));
        pk_clear_s = (state_q == ST_WRITE) || rearm_s;
    end

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (pk_clear_s),
        .load_i       (pk_load_s),
        .data_i       (in_data),
        .word_empty_o (word_empty_s),
        .word_full_o  (word_full_s),
        .word_next_o  (word_next_s)
    );

    // Loader FSM with its address/word counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            start_q <= 1'b0;
            error_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= {AW{1'b0}};
            wdata_q <= 32'h0000_0000;
            words_q <= {WCW{1'b0}};
        end else begin
            we_q    <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (overflow_s) begin
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (complete_s) begin
                        we_q    <= 1'b1;
                        wdata_q <= word_next_s;
                        last_q  <= in_last;
                        state_q <= ST_WRITE;
                    end else if (hs_s) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    addr_q  <= addr_q + AW'(ADDR_STEP);
                    words_q <= words_q + WCW'(1);
                    if (last_q) begin
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_START: begin
                    state_q <= ST_DONE;
                end
                ST_DONE, ST_ERR: begin
                    if (rearm_s) begin
                        addr_q  <= {AW{1'b0}};
                        words_q <= {WCW{1'b0}};
                        error_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign busy     = busy_s;
    assign we_IM    = we_q;
    assign addr_IM  = addr_q;
    assign wdata_IM = wdata_q;
    assign start    = start_q;
    assign error    = error_q;
    assign words    = words_q;

    imem_loader_checker #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WCW   (WCW)
    ) u_checker (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (we_q),
        .addr_i  (addr_q),
        .start_i (start_q),
        .busy_i  (busy_s),
        .ready_i (in_ready_s),
        .error_i (error_q),
        .words_i (words_q)
    );

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake and assembles little-endian 32-bit instructions. Writes each instruction into the instruction-memory write port at consecutive word-aligned byte addresses. After the last word is written, it pulses the processor's `start` input, so it is the producer side of the program memory the processor fetches from.

## Interface

Parameters:
- `DEPTH`, 256: instruction memory size in words; the write address never reaches `4*DEPTH`.
- `AW`, 32: width of the byte address driven to instruction memory.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `in_valid`  in  1  byte stream valid.
- `in_data`  in  8  byte stream data.
- `in_last`  in  1  marks the final byte of the program; qualified by the handshake.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  one-cycle request to re-arm from DONE or ERR.
- `we_IM`  out  1  instruction memory write enable.
- `addr_IM`  out  AW  word-aligned byte address for the write.
- `wdata_IM`  out  32  instruction word.
- `start`  out  1  one-cycle pulse to the processor after a successful load.
- `busy`  out  1  high in LOAD and WRITE.
- `error`  out  1  sticky overflow flag; cleared by `reload` or reset.
- `words`  out  $clog2(DEPTH)+1  count of words written in the current load.

## Operation

- Byte transfer happens when `in_valid && in_ready` (the handshake).
- States: IDLE, LOAD, WRITE, START, DONE, ERR.
- **IDLE:**
  - `in_ready`=1.
  - The first handshake stores byte 0 and moves to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - Byte k of the word goes to bits [8k+7:8k]; k runs 0..3.
  - On the 4th byte, or on any byte with `in_last`=1, go to WRITE.
  - Lanes not yet filled are written as 0.
- **WRITE:**
  - `we_IM`=1 for exactly one cycle, with `addr_IM` = current address and `wdata_IM` = assembled word.
  - `in_ready`=0.
  - Then the address increases by 4, `words` increases by 1, and the byte lane and word buffer clear.
  - If the word was marked last, go to START; otherwise go to LOAD.
- **Overflow:** if a handshake would begin a word when `words`==DEPTH, that byte is accepted and discarded, `error` is set, and the state goes to ERR. No write occurs.
- **START:** `start`=1 for one cycle, then go to DONE.
- **DONE / ERR:**
  - `in_ready`=0.
  - `reload`=1 returns to IDLE and clears the address, `words`, `error` and the byte lane.
- `reload` is ignored in IDLE, LOAD, WRITE and START.
- `in_last` on byte 3 of a word behaves the same as a normal full word that is also the last.
- An empty program cannot occur: `in_last` always arrives with a byte.

## Timing

- Reset (`rst`=0, asynchronous): state IDLE, and every output is 0 except `in_ready`=1 (combinational from IDLE).
  - Cleared values: `we_IM`=0, `addr_IM`=0, `wdata_IM`=0, `start`=0, `busy`=0, `error`=0, `words`=0.
- Reset during WRITE suppresses the pending write. Instruction memory contents are not the loader's responsibility.
- **Write latency:** the completing byte is accepted at edge N; `we_IM` is high in cycle N+1; `in_ready` returns in cycle N+2.
- **Start latency:** the last word is written in cycle N+1 and `start` is high in cycle N+2.
- **Throughput:** 5 cycles per word at best.
- `in_ready` is a function of state only, so there is no combinational path from `in_valid`.
- All outputs are registered except `in_ready` and `busy`, which are decoded from the state register.

## Structure

- Shared package `loader_pkg` holds:
  - state enum `loader_state_t`;
  - `WORD_BYTES`=4;
  - `ADDR_STEP`=4.
- The processor's instruction memory module is extended with a write port (`we_IM`, `addr_IM`, `wdata_IM`). The fetch side is unchanged.
- One sub-module, `byte_packer`:
  - holds the lane counter and the 32-bit little-endian assembly register;
  - signals `word_full`;
  - has clear and load inputs.
- The FSM, address counter, word counter and error flag stay in `imem_loader`.

## Test plan

1. **Two full words.** Send bytes 0x13,0x00,0xA0,0xE3 then 0x01,0x10,0x81,0xE2, with `in_last` on the final byte.
   - Writes E3A00013@0x0 and E2811001@0x4.
   - `start` pulses once, 1 cycle after the 2nd write.
   - `words`=2.
2. **Partial last word.** Send bytes 0xAA,0xBB with `in_last` on 0xBB.
   - Writes 0x0000BBAA@0x0.
   - `start` pulses.
3. **Back-pressure and gaps.** Hold `in_valid` high continuously and toggle it randomly.
   - `in_ready`=0 exactly in WRITE/START/DONE cycles.
   - No byte is lost or duplicated.
   - Writes match a reference model.
4. **Overflow.** With DEPTH=2, send 9 bytes with no `in_last`.
   - Two writes occur; the 9th byte sets `error`=1 with no third write.
   - `reload` clears `error`, `words` and `addr_IM`.
5. **Reset mid-write.** Drive `rst`=0 asynchronously in the WRITE cycle.
   - `we_IM` drops immediately and all outputs take their reset values.
   - A fresh load then starts at 0x0.
6. **Re-arm.** After DONE, pulse `reload`, then load 1 word.
   - Write goes to 0x0.
   - `start` pulses again.
   - `reload` pulsed during LOAD has no effect.
